// File: rtl/instr_fetch_memory.sv
// -----------------------------------------------------------------------------
// instr_fetch_memory
//
// Clocked instruction memory for the processor front end. The fetch stage
// presents byte addresses on a valid/ready request channel and receives the
// instruction word from a one-entry response register on the following cycle.
// A programming port loads the program image. Misaligned and out-of-range
// fetches return NOP_VALUE with a fault code, and are counted.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   prog_we      programming write enable (blocks fetch acceptance)
//   prog_addr    byte address of the word to write
//   prog_data    word to write
//   prog_err     one-cycle pulse: previous programming write was dropped
//   req_valid    fetch request valid
//   req_ready    fetch request can be accepted this cycle (combinational)
//   req_addr     fetch byte address
//   resp_valid   response register holds a response
//   resp_ready   consumer takes the response at this edge
//   resp_instr   fetched word, NOP_VALUE when faulted
//   resp_fault   {out_of_range, misaligned}
//   fetch_count  accepted fetches, wrapping
//   fault_count  faulted fetches, saturating at all ones
// -----------------------------------------------------------------------------
module instr_fetch_memory #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_err,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_instr,
  output logic [1:0]            resp_fault,
  output logic [CNT_WIDTH-1:0]  fetch_count,
  output logic [CNT_WIDTH-1:0]  fault_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode. The word index is kept at full address width so the range
  // check sees every upper bit; only the low bits address the array, and an
  // out-of-range index never reaches the response register.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [ADDR_WIDTH-1:0] prog_idx;
  logic                  req_misaligned;
  logic                  req_out_of_range;
  logic                  prog_bad;
  logic [1:0]            req_fault;
  logic                  accept;

  assign req_idx          = req_addr >> OFF_W;
  assign prog_idx         = prog_addr >> OFF_W;
  assign req_misaligned   = |(req_addr & OFF_MASK);
  assign req_out_of_range = (req_idx >= DEPTH_A);
  assign prog_bad         = (|(prog_addr & OFF_MASK)) || (prog_idx >= DEPTH_A);
  assign req_fault        = {req_out_of_range, req_misaligned};

  // A programming write owns the cycle, so a fetch never races a write.
  assign resp_valid = (state == FULL);
  assign req_ready  = !prog_we && (!resp_valid || resp_ready);
  assign accept     = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Program memory
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of reset; a reset-clearable array
  // cannot map onto block RAM, and the program image must survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && !prog_bad) begin
      mem[prog_idx[IDX_W-1:0]] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Response buffer state
  // ---------------------------------------------------------------------------
  // NOTE: state and registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: begin
        if (accept) state_next = FULL;
      end
      FULL: begin
        // A new acceptance while full implies resp_ready, so the old entry
        // leaves at the same edge the new one arrives.
        if (accept)          state_next = FULL;
        else if (resp_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response register, programming error pulse and counters. The response
  // register only loads on acceptance, which cannot happen during a stall, so
  // the outputs hold for as long as resp_ready stays low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_instr  <= NOP_VALUE;
      resp_fault  <= 2'b00;
      prog_err    <= 1'b0;
      fetch_count <= '0;
      fault_count <= '0;
    end else begin
      prog_err <= prog_we && prog_bad;
      if (accept) begin
        resp_fault  <= req_fault;
        resp_instr  <= (req_fault == 2'b00) ? mem[req_idx[IDX_W-1:0]] : NOP_VALUE;
        fetch_count <= fetch_count + CNT_WIDTH'(1);
        if ((req_fault != 2'b00) && (fault_count != CNT_MAX)) begin
          fault_count <= fault_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_memory.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_memory
//
// Scoreboard bench. A predictor on the rising edge works out, from the
// interface rules alone, whether a request is accepted and what it must
// return, and queues that expectation. A monitor on the falling edge compares
// the presented response, handshake and counters against the predictor. A
// directed sequence walks the documented scenarios, then randomized traffic
// runs, and a second instance with 2-bit counters checks wrap/saturation.
// -----------------------------------------------------------------------------
module tb_instr_fetch_memory;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 64;
  localparam int          CW    = 16;
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic          prog_err;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_instr;
  logic [1:0]    resp_fault;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] fault_count;

  // Second instance: 2-bit counters.
  logic          c2_reset = 1'b1;
  logic          c2_prog_we = 1'b0;
  logic [AW-1:0] c2_prog_addr = '0;
  logic [DW-1:0] c2_prog_data = '0;
  logic          c2_prog_err;
  logic          c2_req_valid = 1'b0;
  logic          c2_req_ready;
  logic [AW-1:0] c2_req_addr = '0;
  logic          c2_resp_valid;
  logic          c2_resp_ready = 1'b1;
  logic [DW-1:0] c2_resp_instr;
  logic [1:0]    c2_resp_fault;
  logic [1:0]    c2_fetch_count;
  logic [1:0]    c2_fault_count;

  always #5 clk = ~clk;

  instr_fetch_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_VALUE(NOP), .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_fault(resp_fault), .fetch_count(fetch_count), .fault_count(fault_count)
  );

  instr_fetch_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_VALUE(NOP), .CNT_WIDTH(2)
  ) u_dut2 (
    .clk(clk), .reset(c2_reset),
    .prog_we(c2_prog_we), .prog_addr(c2_prog_addr), .prog_data(c2_prog_data),
    .prog_err(c2_prog_err),
    .req_valid(c2_req_valid), .req_ready(c2_req_ready), .req_addr(c2_req_addr),
    .resp_valid(c2_resp_valid), .resp_ready(c2_resp_ready), .resp_instr(c2_resp_instr),
    .resp_fault(c2_resp_fault), .fetch_count(c2_fetch_count), .fault_count(c2_fault_count)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
  } resp_t;

  resp_t       sb_q[$];
  logic [31:0] mem_m [DEPTH];
  bit          m_valid    = 1'b0;
  bit          m_prog_err = 1'b0;
  bit          started    = 1'b0;
  int unsigned m_fetch    = 0;
  int unsigned m_fault    = 0;

  function automatic bit addr_ok(input logic [31:0] a);
    return ((a % 4) == 0) && ((a / 4) < DEPTH);
  endfunction

  function automatic resp_t predict(input logic [31:0] a);
    resp_t       r;
    logic [31:0] w;
    w          = a / 4;
    r.fault[0] = (a % 4) != 0;
    r.fault[1] = w >= DEPTH;
    r.instr    = (r.fault == 2'b00) ? mem_m[w[IW-1:0]] : NOP;
    return r;
  endfunction

  // Predictor: inputs are stable here because they only change 1 ns after an
  // edge or just after a falling edge.
  always @(posedge clk) begin : model
    resp_t       r;
    bit          acc;
    logic [31:0] w;
    if (reset) begin
      sb_q.delete();
      m_valid    <= 1'b0;
      m_prog_err <= 1'b0;
      m_fetch    <= 0;
      m_fault    <= 0;
      started    <= 1'b1;
    end else begin
      m_prog_err <= prog_we && !addr_ok(prog_addr);
      if (prog_we && addr_ok(prog_addr)) begin
        w = prog_addr / 4;
        mem_m[w[IW-1:0]] <= prog_data;
      end
      acc = req_valid && !prog_we && (!m_valid || resp_ready);
      if (acc) begin
        r = predict(req_addr);
        sb_q.push_back(r);
        m_fetch <= (m_fetch + 1) % (1 << CW);
        if (r.fault != 2'b00 && m_fault < (1 << CW) - 1) m_fault <= m_fault + 1;
      end
      m_valid <= acc || (m_valid && !resp_ready);
    end
  end

  // Monitor: compares whatever the DUT presents against the model.
  always @(negedge clk) begin
    if (started) begin
      check("req_ready", 64'(req_ready), 64'(!prog_we && (!m_valid || resp_ready)));
      check("resp_valid", 64'(resp_valid), 64'(m_valid));
      check("prog_err", 64'(prog_err), 64'(m_prog_err));
      check("fetch_count", 64'(fetch_count), 64'(m_fetch));
      check("fault_count", 64'(fault_count), 64'(m_fault));
      if (resp_valid) begin
        check("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
          check("resp_instr", 64'(resp_instr), 64'(sb_q[0].instr));
          check("resp_fault", 64'(resp_fault), 64'(sb_q[0].fault));
          if (resp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to just after the falling edge: outputs of the current cycle visible,
  // and safe to change inputs without racing the monitor.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    cyc();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      1:       return 32'(4 * $urandom_range(DEPTH, DEPTH + 200));
      2:       return 32'($urandom);
      default: return 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    settle();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_instr", 64'(resp_instr), 64'(NOP));
    check("rst_resp_fault", 64'(resp_fault), 64'd0);
    check("rst_prog_err", 64'(prog_err), 64'd0);
    check("rst_fetch_count", 64'(fetch_count), 64'd0);
    check("rst_fault_count", 64'(fault_count), 64'd0);

    // Load the whole array, then the test program.
    for (int i = 0; i < DEPTH; i++) prog(32'(4 * i), $urandom);
    prog(32'h00, 32'h2010_0004);
    prog(32'h04, 32'h2008_0001);
    prog(32'h0C, 32'h1208_0002);

    // Back-to-back fetches, one response per cycle.
    pulse_reset();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h00;
    cyc();
    req_addr = 32'h04;
    settle();
    check("b2b_valid0", 64'(resp_valid), 64'd1);
    check("b2b_instr0", 64'(resp_instr), 64'h2010_0004);
    cyc();
    req_addr = 32'h0C;
    settle();
    check("b2b_valid1", 64'(resp_valid), 64'd1);
    check("b2b_instr1", 64'(resp_instr), 64'h2008_0001);
    cyc();
    req_valid = 1'b0;
    settle();
    check("b2b_valid2", 64'(resp_valid), 64'd1);
    check("b2b_instr2", 64'(resp_instr), 64'h1208_0002);
    check("b2b_fault2", 64'(resp_fault), 64'd0);
    check("b2b_fetch_count", 64'(fetch_count), 64'd3);

    // Faulted fetches
    cyc();
    pulse_reset();
    req_valid = 1'b1;
    req_addr  = 32'h02;
    cyc();
    req_addr = 32'h100;
    settle();
    check("flt_misaligned", 64'(resp_fault), 64'b01);
    check("flt_instr0", 64'(resp_instr), 64'(NOP));
    cyc();
    req_addr = 32'h102;
    settle();
    check("flt_out_of_range", 64'(resp_fault), 64'b10);
    check("flt_instr1", 64'(resp_instr), 64'(NOP));
    cyc();
    req_valid = 1'b0;
    settle();
    check("flt_both", 64'(resp_fault), 64'b11);
    check("flt_instr2", 64'(resp_instr), 64'(NOP));
    check("flt_fault_count", 64'(fault_count), 64'd3);
    check("flt_fetch_count", 64'(fetch_count), 64'd3);
    cyc();

    // Stall for four cycles with a request waiting, then release together
    // with that request.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h00;
    cyc();
    req_addr = 32'h04;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_resp_valid", 64'(resp_valid), 64'd1);
      check("stall_instr", 64'(resp_instr), 64'h2010_0004);
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    settle();
    check("release_valid", 64'(resp_valid), 64'd1);
    check("release_instr", 64'(resp_instr), 64'h2008_0001);
    cyc();

    // Write and fetch presented together; write wins the cycle.
    prog_we   = 1'b1;
    prog_addr = 32'h04;
    prog_data = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    req_addr  = 32'h04;
    settle();
    check("conflict_req_ready", 64'(req_ready), 64'd0);
    cyc();
    prog_we = 1'b0;
    settle();
    check("after_write_req_ready", 64'(req_ready), 64'd1);
    cyc();
    req_valid = 1'b0;
    settle();
    check("new_data", 64'(resp_instr), 64'hDEAD_BEEF);
    cyc();
    prog(32'h06, 32'h1111_1111);
    settle();
    check("prog_err_pulse", 64'(prog_err), 64'd1);
    cyc();
    settle();
    check("prog_err_clear", 64'(prog_err), 64'd0);
    req_valid = 1'b1;
    req_addr  = 32'h04;
    cyc();
    req_valid = 1'b0;
    settle();
    check("dropped_write_unchanged", 64'(resp_instr), 64'hDEAD_BEEF);
    cyc();

    // Reset while full; the write and request in the reset cycle are ignored.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h08;
    cyc();
    req_valid = 1'b0;
    settle();
    check("pre_reset_valid", 64'(resp_valid), 64'd1);
    reset     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 32'h00;
    prog_data = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    req_addr  = 32'h0C;
    cyc();
    reset     = 1'b0;
    prog_we   = 1'b0;
    req_valid = 1'b0;
    settle();
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_fetch_count", 64'(fetch_count), 64'd0);
    check("mid_rst_fault_count", 64'(fault_count), 64'd0);
    check("mid_rst_instr", 64'(resp_instr), 64'(NOP));
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h00;
    cyc();
    req_valid = 1'b0;
    settle();
    check("post_rst_instr", 64'(resp_instr), 64'h2010_0004);
    cyc();

    // Randomized traffic, checked entirely by the scoreboard.
    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      prog_we    = ($urandom_range(0, 9) == 0);
      prog_addr  = rand_addr();
      prog_data  = $urandom;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = rand_addr();
      resp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    reset      = 1'b0;
    prog_we    = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (3) cyc();

    // 2-bit counters: five misaligned fetches.
    c2_reset = 1'b1;
    cyc();
    c2_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c2_req_valid = 1'b1;
      c2_req_addr  = 32'(4 * i + 1);
      cyc();
    end
    c2_req_valid = 1'b0;
    settle();
    check("c2_fault_count_sat", 64'(c2_fault_count), 64'd3);
    check("c2_fetch_count_wrap", 64'(c2_fetch_count), 64'd1);
    check("c2_fault", 64'(c2_resp_fault), 64'b01);
    check("c2_instr", 64'(c2_resp_instr), 64'(NOP));
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
